seven_seg_mux_ctrl: RTL and testbench
=====================================

// Module: seven_seg_mux_ctrl
// PURPOSE
//  Parametrised multiplexed N-digit seven-segment controller for board-level result display.
//  Accepts a binary value over a valid/ready load port and converts it to BCD with an
//  iterative double-dabble engine. In hex mode it skips conversion and shows raw nibbles.
//  Time-multiplexes the digits onto shared segment lines. Sits between processor debug taps and FPGA pins.
// PARAMETERS
//  DIGITS        4   number of digits/anodes, 1..8
//  DATA_W        16  width of load_data, 1..32
//  REFRESH_BITS  18  dwell per digit = 2^REFRESH_BITS clk_100mhz cycles
// PORTS
//  clk_100mhz  in   1         single clock; all logic on posedge
//  reset       in   1         synchronous, active-high
//  load_valid  in   1         load request
//  load_ready  out  1         high only in IDLE
//  load_data   in   DATA_W    unsigned binary value to display
//  hex_mode    in   1         sampled at acceptance: 1 = hex nibbles, 0 = decimal
//  busy        out  1         conversion in progress
//  overflow    out  1         last accepted decimal value > 10^DIGITS-1 (sticky until next accept)
//  anode       out  DIGITS    active-low one-hot digit enable; bit 0 = least-significant digit
//  seg         out  7         active-low {a,b,c,d,e,f,g}; '0'=7'b0000001, '-'=7'b1111110, blank=7'b1111111
// BEHAVIOUR
//  Reset (sync): state=IDLE, disp_reg=0, overflow=0, busy=0, load_ready=1 after the clock edge,
//   refresh counter=0, digit_idx=0, anode={DIGITS{1'b1}}, seg=7'b1111111.
//  FSM IDLE -> CONV -> DONE -> IDLE.
//   IDLE: load_ready=1. load_valid&&load_ready at edge N accepts data. Decimal: -> CONV. Hex: -> DONE.
//   CONV: busy=1, load_ready=0. Exactly DATA_W shift/add-3 steps, one per cycle,
//    over a 4*DIGITS+DATA_W shift register. -> DONE after the last step.
//   DONE: latch disp_reg, -> IDLE. busy=0 in DONE.
//  Latency, accept edge to disp_reg update: decimal N+DATA_W+1; hex N+1 (disp_reg updated at edge N+1).
//  load_valid while not ready: ignored, no queuing. Data must be re-presented.
//  Overflow: compared at acceptance against constant 10^DIGITS-1. If set, disp_reg is forced
//   to all dashes at DONE. Hex mode: overflow=0; nibbles above DIGITS*4 bits are dropped.
//  Hex mode digit values 0..F. Glyphs A,b,C,d,E,F: standard. Decimal digits never exceed 9.
//  Refresh: free-running REFRESH_BITS+$clog2(DIGITS) counter. digit_idx = top bits, wraps
//   DIGITS-1 -> 0. Non-power-of-2 DIGITS: index saturating-wraps (reset to 0 when reaching DIGITS).
//  anode/seg are registered: they reflect digit_idx and disp_reg one cycle later. Exactly one anode low at a time.
//  Display stays stable through a conversion. disp_reg changes only in DONE, never partially.
//  Reset mid-CONV: conversion aborted; display returns to 0 per reset values.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: in decimal mode, zero digits above the most-significant
//   non-zero digit show blank. Value 0 shows a single '0' on digit 0. Hex mode and dashes are unaffected.
//  Undefined: all digits are shown, including leading zeros.
// TESTING (DIGITS=4, DATA_W=16, REFRESH_BITS=2 for sim)
//  1. Load 16'd6765 decimal -> busy for 16 cycles; disp digits 3..0 = 6,7,6,5; overflow=0.
//  2. Load 16'd10000 decimal -> overflow=1; all four digits seg=7'b1111110.
//  3. Load 16'hBEEF, hex_mode=1 -> disp updates at N+1; digits b,E,E,F; busy never asserted.
//  4. load_valid held during CONV with 16'd1234 -> load_ready=0, value ignored; first value stays.
//  5. reset asserted 5 cycles into CONV -> next cycle state IDLE, disp=0000, load_ready=1.
//  6. LEADING_ZERO_BLANK_EN, load 16'd42 -> digits 3,2 blank, digits 1,0 = 4,2. Load 0 -> only digit 0 = '0'.
//  All: check anode rotation 1110,1101,1011,0111 with 4-cycle dwell, and single-low invariant.

Source files
------------

// File: rtl/seven_seg_mux_ctrl.sv
// Multiplexed N-digit seven-segment controller: binary load, double-dabble BCD
// or raw hex nibbles, digit time-multiplexing. Optional macro: LEADING_ZERO_BLANK_EN.
// Ports: clk_100mhz, reset (sync, active-high), load_valid/load_ready/load_data,
//   hex_mode, busy, overflow, anode (active-low one-hot), seg (active-low a..g).
module seven_seg_mux_ctrl #(
  parameter int DIGITS       = 4,
  parameter int DATA_W       = 16,
  parameter int REFRESH_BITS = 18
) (
  input  logic              clk_100mhz,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              hex_mode,
  output logic              busy,
  output logic              overflow,
  output logic [DIGITS-1:0] anode,
  output logic [6:0]        seg
);

  localparam int DW = 4 * DIGITS;
  localparam int SW = DW + DATA_W;
  localparam int CW = $clog2(DATA_W + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [63:0] pow10m1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAXV = pow10m1(DIGITS);

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST =
    {DIGITS{1'b1}} ^ DIGITS'(1);
`else
  localparam logic [DIGITS-1:0] BLANK_RST = '0;
`endif

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  state_e            state_q;
  logic [SW-1:0]     sr_q, sr_d;
  logic [SW-1:0]     data_ext;
  logic [CW-1:0]     cnt_q;
  logic              ovf_q, hex_q;
  logic [DW-1:0]     disp_q;
  logic              dash_q;
  logic [DIGITS-1:0] blank_q, blank_d;

  assign data_ext   = SW'(load_data);
  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q == CONV);
  assign overflow   = ovf_q;

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift.
  always_comb begin
    sr_d = sr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr_d[DATA_W+4*i +: 4] >= 4'd5)
        sr_d[DATA_W+4*i +: 4] = sr_d[DATA_W+4*i +: 4] + 4'd3;
    end
    sr_d = sr_d << 1;
  end

  // Leading-zero mask, computed from the finished result so it lands
  // in the same edge as the digits it belongs to.
  always_comb begin
    blank_d = '0;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic seen;
      seen = hex_q | ovf_q;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (!seen && sr_q[DATA_W+4*i +: 4] == 4'd0)
          blank_d[i] = 1'b1;
        else
          seen = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      hex_q   <= 1'b0;
      disp_q  <= '0;
      dash_q  <= 1'b0;
      blank_q <= BLANK_RST;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load_valid) begin
            hex_q <= hex_mode;
            cnt_q <= '0;
            if (hex_mode) begin
              ovf_q   <= 1'b0;
              sr_q    <= {data_ext[DW-1:0], {DATA_W{1'b0}}};
              state_q <= DONE;
            end else begin
              ovf_q   <= (64'(load_data) > MAXV);
              sr_q    <= data_ext;
              state_q <= CONV;
            end
          end
        end
        CONV: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(DATA_W - 1))
            state_q <= DONE;
        end
        DONE: begin
          disp_q  <= sr_q[DATA_W +: DW];
          dash_q  <= ovf_q;
          blank_q <= blank_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [REFRESH_BITS-1:0] ref_q;
  logic [IW-1:0]           idx_q;
  logic [DIGITS-1:0]       anode_q;
  logic [6:0]              seg_q, seg_d;
  logic [3:0]              nib;

  assign nib   = disp_q[4*idx_q +: 4];
  assign anode = anode_q;
  assign seg   = seg_q;

  always_comb begin
    seg_d = 7'b1111111;
    if (dash_q) begin
      seg_d = 7'b1111110;
    end else if (!blank_q[idx_q]) begin
      unique case (nib)
        4'h0: seg_d = 7'b0000001;
        4'h1: seg_d = 7'b1001111;
        4'h2: seg_d = 7'b0010010;
        4'h3: seg_d = 7'b0000110;
        4'h4: seg_d = 7'b1001100;
        4'h5: seg_d = 7'b0100100;
        4'h6: seg_d = 7'b0100000;
        4'h7: seg_d = 7'b0001111;
        4'h8: seg_d = 7'b0000000;
        4'h9: seg_d = 7'b0000100;
        4'hA: seg_d = 7'b0001000;
        4'hB: seg_d = 7'b1100000;
        4'hC: seg_d = 7'b0110001;
        4'hD: seg_d = 7'b1000010;
        4'hE: seg_d = 7'b0110000;
        4'hF: seg_d = 7'b0111000;
        default: seg_d = 7'b1111111;
      endcase
    end
  end

  // Prescaler plus digit index form the refresh counter; the index
  // wraps explicitly so non-power-of-2 digit counts work.
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      ref_q   <= '0;
      idx_q   <= '0;
      anode_q <= {DIGITS{1'b1}};
      seg_q   <= 7'b1111111;
    end else begin
      ref_q <= ref_q + 1'b1;
      if (&ref_q)
        idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      anode_q <= ~(DIGITS'(1) << idx_q);
      seg_q   <= seg_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_mux_ctrl.sv
// Self-checking bench for seven_seg_mux_ctrl (DIGITS=4, DATA_W=16, REFRESH_BITS=2).
// Arithmetic reference model of the displayed glyphs; randomized loads.
module tb_seven_seg_mux_ctrl;
  localparam int D  = 4;
  localparam int W  = 16;
  localparam int RB = 2;

  logic         clk_100mhz = 1'b0;
  logic         reset      = 1'b1;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic [W-1:0] load_data  = '0;
  logic         hex_mode   = 1'b0;
  logic         busy;
  logic         overflow;
  logic [D-1:0] anode;
  logic [6:0]   seg;

  int total = 0;
  int bad   = 0;
  logic [6:0] cur_seg [D];

  seven_seg_mux_ctrl #(
    .DIGITS(D), .DATA_W(W), .REFRESH_BITS(RB)
  ) dut (
    .clk_100mhz(clk_100mhz),
    .reset(reset),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data(load_data),
    .hex_mode(hex_mode),
    .busy(busy),
    .overflow(overflow),
    .anode(anode),
    .seg(seg)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  // Active-high a..g patterns, inverted for the active-low pins.
  function automatic logic [6:0] glyph(input int n);
    logic [6:0] p;
    case (n)
      0: p = 7'b1111110;  1: p = 7'b0110000;
      2: p = 7'b1101101;  3: p = 7'b1111001;
      4: p = 7'b0110011;  5: p = 7'b1011011;
      6: p = 7'b1011111;  7: p = 7'b1110000;
      8: p = 7'b1111111;  9: p = 7'b1111011;
      10: p = 7'b1110111; 11: p = 7'b0011111;
      12: p = 7'b1001110; 13: p = 7'b0111101;
      14: p = 7'b1001111; 15: p = 7'b1000111;
      default: p = 7'b0000000;
    endcase
    return ~p;
  endfunction

  function automatic int low_idx(input logic [D-1:0] a);
    for (int i = 0; i < D; i++) if (!a[i]) return i;
    return -1;
  endfunction

  task automatic set_model(input int v, input bit hx);
    int pw;
    pw = 1;
    for (int i = 0; i < D; i++) begin
      if (!hx && v > 9999) cur_seg[i] = 7'b1111110;
      else if (hx) cur_seg[i] = glyph((v >> (4 * i)) & 15);
      else cur_seg[i] = glyph((v / pw) % 10);
`ifdef LEADING_ZERO_BLANK_EN
      if (!hx && v <= 9999 && i > 0 && v < pw) cur_seg[i] = 7'b1111111;
`endif
      pw = pw * 10;
    end
  endtask

  task automatic tick;
    @(posedge clk_100mhz);
    #1;
  endtask

  task automatic scan(input int cycles);
    int prev, run, idx;
    bit full;
    prev = -1; run = 0; full = 0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      idx = low_idx(anode);
      total++;
      if ($countones(~anode) != 1) begin
        bad++;
        $display("FAIL onehot anode=%b required exactly one low", anode);
      end
      if (idx >= 0) begin
        total++;
        if (seg !== cur_seg[idx]) begin
          bad++;
          $display("FAIL seg digit%0d got=%b want=%b", idx, seg, cur_seg[idx]);
        end
        if (idx == prev) run++;
        else begin
          if (prev >= 0) begin
            total++;
            if (idx != (prev + 1) % D || (full && run != 4)) begin
              bad++;
              $display("FAIL rotate got=%0d after=%0d dwell=%0d want next=%0d dwell=4",
                       idx, prev, run, (prev + 1) % D);
            end
            full = 1;
          end
          prev = idx;
          run = 1;
        end
      end
    end
  endtask

  task automatic wait_ready;
    int n;
    n = 0;
    while (!load_ready && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (!load_ready) begin
      bad++;
      $display("FAIL ready_timeout got=0 want=1");
    end
  endtask

  task automatic run_load(input int v, input bit hx);
    logic [6:0] old [D];
    int lat, idx;
    bit eo;
    old = cur_seg;
    wait_ready();
    load_valid = 1'b1;
    load_data = W'(v);
    hex_mode = hx;
    tick();
    load_valid = 1'b0;
    eo = !hx && v > 9999;
    total++;
    if (overflow !== eo) begin
      bad++;
      $display("FAIL overflow v=%0d got=%b want=%b", v, overflow, eo);
    end
    lat = hx ? 1 : W + 1;
    for (int k = 0; k < lat; k++) begin
      total++;
      if (busy !== (!hx && k < W) || load_ready !== 1'b0) begin
        bad++;
        $display("FAIL busy_ready k=%0d got=%b/%b want=%b/0",
                 k, busy, load_ready, !hx && k < W);
      end
      tick();
    end
    idx = low_idx(anode);
    total++;
    if (idx < 0 || seg !== old[idx] || load_ready !== 1'b1) begin
      bad++;
      $display("FAIL pre_update seg=%b rdy=%b want old glyph rdy=1", seg, load_ready);
    end
    tick();
    set_model(v, hx);
    idx = low_idx(anode);
    total++;
    if (idx < 0 || seg !== cur_seg[idx]) begin
      bad++;
      $display("FAIL post_update v=%0d seg=%b want new glyph", v, seg);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    total++;
    if (load_ready !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0 ||
        anode !== 4'b1111 || seg !== 7'b1111111) begin
      bad++;
      $display("FAIL reset rdy=%b busy=%b ovf=%b an=%b seg=%b want 1 0 0 1111 1111111",
               load_ready, busy, overflow, anode, seg);
    end
    reset = 1'b0;
    set_model(0, 0);
    scan(36);
  endtask

  task automatic test_decimal;
    run_load(6765, 0);
    scan(20);
  endtask

  task automatic test_overflow;
    run_load(10000, 0);
    scan(20);
  endtask

  task automatic test_hex;
    run_load(16'hBEEF, 1);
    scan(20);
  endtask

  task automatic test_ignore;
    wait_ready();
    load_valid = 1'b1;
    load_data = 16'd321;
    hex_mode = 1'b0;
    tick();
    load_data = 16'd1234;
    for (int k = 0; k <= W; k++) begin
      total++;
      if (load_ready !== 1'b0) begin
        bad++;
        $display("FAIL ignore_ready k=%0d got=%b want=0", k, load_ready);
      end
      if (k < W) tick();
    end
    load_valid = 1'b0;
    tick(); tick();
    total++;
    if (load_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ignore_idle rdy=%b busy=%b want 1 0", load_ready, busy);
    end
    set_model(321, 0);
    scan(20);
  endtask

  task automatic test_small_values;
    run_load(42, 0);
    scan(20);
    run_load(0, 0);
    scan(20);
  endtask

  task automatic test_random;
    int v;
    bit hx;
    for (int n = 0; n < 10; n++) begin
      hx = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: v = int'($urandom_range(0, 9999));
        1: v = int'($urandom_range(0, 65535));
        default: v = int'($urandom_range(0, 99));
      endcase
      run_load(v, hx);
      scan(20);
    end
  endtask

  task automatic test_reset_mid_conv;
    run_load(8888, 0);
    wait_ready();
    load_valid = 1'b1;
    load_data = 16'd9999;
    hex_mode = 1'b0;
    tick();
    load_valid = 1'b0;
    repeat (5) tick();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL midconv_busy got=%b want=1", busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (load_ready !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0 ||
        anode !== 4'b1111 || seg !== 7'b1111111) begin
      bad++;
      $display("FAIL abort rdy=%b busy=%b ovf=%b an=%b seg=%b want 1 0 0 1111 1111111",
               load_ready, busy, overflow, anode, seg);
    end
    set_model(0, 0);
    scan(24);
  endtask

  initial begin
    test_reset();
    test_decimal();
    test_overflow();
    test_hex();
    test_ignore();
    test_small_values();
    test_random();
    test_reset_mid_conv();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
